kbd_event_decoder: RTL and testbench
====================================

# kbd_event_decoder

Parametrised PS/2 scan-code decoder between the `ps2_keyboard` byte receiver and display/CPU consumers. Consumes the Set-2 byte stream and tracks E0 (extended) and F0 (break) prefixes. It also tracks shift state and suppresses typematic repeat. Decoded key events are pushed into an internal FIFO with a valid/ready read port, and the block keeps a saturating key-press counter and a sticky overflow flag.

## Interface
Parameters:
- `DEPTH`, 8, event FIFO depth; power of two, ≥2
- `CNT_W`, 8, press-counter width

Ports:
- `clk`  in  1  system clock; all state on rising edge
- `clrn`  in  1  asynchronous active-low reset
- `in_data`  in  8  byte from receiver
- `in_valid`  in  1  one-cycle strobe per byte; always consumed that cycle
- `ev_valid`  out  1  FIFO non-empty
- `ev_ready`  in  1  consumer pops head when `ev_valid & ev_ready`
- `ev_code`  out  8  head: scan code (prefixes stripped)
- `ev_ext`  out  1  head: code was E0-prefixed
- `ev_break`  out  1  head: release event
- `ev_ascii`  out  8  head: ASCII, 0x00 if unmapped or extended
- `press_count`  out  CNT_W  number of non-repeat make events, saturating
- `shift`  out  1  left (0x12) or right (0x59) shift currently held
- `overflow`  out  1  sticky: an event was dropped on a full FIFO
- `clr_ovf`  in  1  synchronous clear of `overflow`

## Operation
- Prefix FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
- IDLE: E0→EXT; F0→BRK; other byte→make event, ext=0.
- EXT: F0→EXT_BRK; E0→EXT; other→make event, ext=1, →IDLE.
- BRK: E0→IDLE and discard; F0→BRK; other→break event, ext=0, →IDLE.
- EXT_BRK: any byte except E0/F0→break event, ext=1, →IDLE; E0/F0→IDLE, discarded.
- Make event with {ext,code} equal to the held key register is a typematic repeat. It is not pushed and does not count.
- Non-repeat make: push event, load the held register, and increment `press_count`, saturating at all-ones.
- Break: push event. If {ext,code} matches the held register, clear it.
- Shift flags update on non-extended make/break of 0x12/0x59. Shift events are pushed like any other key.
- ASCII mapping, non-extended only: 0x16/1E/26/25/2E/36/3D/3E/46/45 → '1'..'9','0'. Letters map lower case ('a' for 0x1C), upper case while `shift`. 0x29→0x20 and 0x5A→0x0D. All other codes →0x00.
- ASCII is computed from the shift state before the event's own shift update and stored in the FIFO entry.
- Push while full: event dropped and `overflow` set. If a pop happens the same cycle, the push succeeds and `overflow` is unchanged.
- `clr_ovf` and a drop in the same cycle: `overflow` stays 1.

## Timing
- Reset values: FSM=IDLE, FIFO empty, `ev_valid`=0, `ev_code`/`ev_ascii`=0x00, `ev_ext`/`ev_break`=0, `press_count`=0, `shift`=0, `overflow`=0, held register invalid.
- Latency: a terminating byte strobed in cycle N gives `ev_valid`=1 in cycle N+1 when the FIFO was empty.
- The counter and `shift` are visible in N+1.
- Head fields are registered FIFO outputs, stable while `ev_valid & ~ev_ready`.
- Throughput: one byte per cycle, one push and one pop per cycle simultaneously. Pointers are log2(DEPTH)+1 bits and wrap naturally.
- Asserting `clrn` mid-sequence, e.g. after E0, returns the FSM to IDLE and discards the partial prefix.

## Structure
- Shared header `kbd_pkg.vh` holds the constants 8'hE0, 8'hF0, 8'h12 and 8'h59, plus the 2-bit FSM state encodings.
- One combinational sub-module, `kbd_scan2ascii` (code, ext, shift → ascii).
- The FIFO is inline and 18 bits wide: {ascii, ext, break, code}.

## Test plan
- Reset, then bytes 1C, F0 1C with `ev_ready`=1 → events {1C, make, 'a'=0x61} and {1C, break, 0x61}; `press_count`=1.
- Bytes 12, 1C, 1C, 1C, F0 1C, F0 12 → 4 events pushed (the two repeats are suppressed); the 1C make carries ascii 0x41; `press_count`=2; `shift`=0 at end.
- Bytes E0 75, E0 F0 75 → {75, ext=1, make, 0x00} then {75, ext=1, break}.
- `ev_ready`=0 with DEPTH=8, 9 distinct makes → 8 entries held and `overflow`=1. `clr_ovf` clears it; the first popped entry is the first make.
- FIFO full plus simultaneous push and pop → no drop and `overflow` stays 0. Reset asserted after E0, then 16 → non-extended make {16, '1'=0x31}.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared constants, prefix-FSM encodings and the FIFO entry layout for the
// PS/2 Set-2 event decoder.
package kbd_pkg;

  localparam logic [7:0] KC_EXT    = 8'hE0;
  localparam logic [7:0] KC_BRK    = 8'hF0;
  localparam logic [7:0] KC_LSHIFT = 8'h12;
  localparam logic [7:0] KC_RSHIFT = 8'h59;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } kbd_state_e;

  // 18-bit FIFO entry: {ascii, ext, break, code}
  typedef struct packed {
    logic [7:0] ascii;
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } kbd_event_t;

endpackage

// File: rtl/kbd_scan2ascii.sv
// Combinational Set-2 scan code to ASCII lookup; extended codes and unmapped
// codes give 0x00, letters become upper case while shift is held.
module kbd_scan2ascii (
  input  logic [7:0] code,
  input  logic       ext,
  input  logic       shift,
  output logic [7:0] ascii
);

  logic [7:0] base;
  logic       is_letter;

  always_comb begin
    base      = 8'h00;
    is_letter = 1'b1;
    case (code)
      8'h1C: base = "a";  8'h32: base = "b";  8'h21: base = "c";
      8'h23: base = "d";  8'h24: base = "e";  8'h2B: base = "f";
      8'h34: base = "g";  8'h33: base = "h";  8'h43: base = "i";
      8'h3B: base = "j";  8'h42: base = "k";  8'h4B: base = "l";
      8'h3A: base = "m";  8'h31: base = "n";  8'h44: base = "o";
      8'h4D: base = "p";  8'h15: base = "q";  8'h2D: base = "r";
      8'h1B: base = "s";  8'h2C: base = "t";  8'h3C: base = "u";
      8'h2A: base = "v";  8'h1D: base = "w";  8'h22: base = "x";
      8'h35: base = "y";  8'h1A: base = "z";
      default: begin
        is_letter = 1'b0;
        case (code)
          8'h16: base = "1";  8'h1E: base = "2";  8'h26: base = "3";
          8'h25: base = "4";  8'h2E: base = "5";  8'h36: base = "6";
          8'h3D: base = "7";  8'h3E: base = "8";  8'h46: base = "9";
          8'h45: base = "0";  8'h29: base = 8'h20; 8'h5A: base = 8'h0D;
          default: base = 8'h00;
        endcase
      end
    endcase

    if (ext)
      ascii = 8'h00;
    else if (is_letter && shift)
      ascii = base - 8'h20;
    else
      ascii = base;
  end

endmodule

// File: rtl/kbd_event_decoder.sv
// PS/2 Set-2 byte stream decoder: strips E0/F0 prefixes, tracks shift,
// suppresses typematic repeats and queues key events in a valid/ready FIFO.
module kbd_event_decoder
  import kbd_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [7:0]       ev_code,
  output logic             ev_ext,
  output logic             ev_break,
  output logic [7:0]       ev_ascii,
  output logic [CNT_W-1:0] press_count,
  output logic             shift,
  output logic             overflow,
  input  logic             clr_ovf,
  output logic [1:0]       dbg_state
);

  localparam int AW = $clog2(DEPTH);

  // Handshake: the head entry is transferred on any cycle where
  // ev_valid & ev_ready; ev_valid never depends on ev_ready.

  kbd_state_e state, state_nx;
  logic       fire, fire_ext, fire_brk, is_prefix;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= ST_IDLE;
    else       state <= state_nx;
  end

  assign is_prefix = (in_data == KC_EXT) || (in_data == KC_BRK);

  always_comb begin
    state_nx = state;
    if (in_valid) begin
      case (state)
        ST_IDLE:    state_nx = (in_data == KC_EXT) ? ST_EXT :
                               (in_data == KC_BRK) ? ST_BRK : ST_IDLE;
        ST_EXT:     state_nx = (in_data == KC_BRK) ? ST_EXT_BRK :
                               (in_data == KC_EXT) ? ST_EXT : ST_IDLE;
        ST_BRK:     state_nx = (in_data == KC_BRK) ? ST_BRK : ST_IDLE;
        ST_EXT_BRK: state_nx = ST_IDLE;
        default:    state_nx = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    fire     = in_valid && !is_prefix;
    fire_ext = (state == ST_EXT) || (state == ST_EXT_BRK);
    fire_brk = (state == ST_BRK) || (state == ST_EXT_BRK);
  end

  assign dbg_state = state;

  logic       held_valid;
  logic [8:0] held_key;
  logic       is_repeat, new_make, push, pop, full, drop;
  logic       lshift, rshift;
  logic [7:0] ascii;

  kbd_scan2ascii u_scan2ascii (
    .code  (in_data),
    .ext   (fire_ext),
    .shift (shift),
    .ascii (ascii)
  );

  assign is_repeat = held_valid && (held_key == {fire_ext, in_data});
  assign new_make  = fire && !fire_brk && !is_repeat;
  assign push      = fire && (fire_brk || !is_repeat);
  assign shift     = lshift | rshift;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      held_valid  <= 1'b0;
      held_key    <= '0;
      press_count <= '0;
      lshift      <= 1'b0;
      rshift      <= 1'b0;
    end else begin
      if (new_make) begin
        held_valid <= 1'b1;
        held_key   <= {fire_ext, in_data};
        if (press_count != {CNT_W{1'b1}}) press_count <= press_count + CNT_W'(1);
      end else if (fire && fire_brk && is_repeat) begin
        held_valid <= 1'b0;
      end
      if (fire && !fire_ext && in_data == KC_LSHIFT) lshift <= !fire_brk;
      if (fire && !fire_ext && in_data == KC_RSHIFT) rshift <= !fire_brk;
    end
  end

  kbd_event_t mem [DEPTH];
  kbd_event_t head;
  logic [AW:0] wr_ptr, rd_ptr;

  assign ev_valid = (wr_ptr != rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = ev_valid && ev_ready;
  // A pop in the same cycle frees the slot the full-FIFO push needs.
  assign drop     = push && full && !pop;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push && !drop) begin
        mem[wr_ptr[AW-1:0]] <= '{ascii: ascii, ext: fire_ext, brk: fire_brk, code: in_data};
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  assign head     = mem[rd_ptr[AW-1:0]];
  assign ev_code  = head.code;
  assign ev_ext   = head.ext;
  assign ev_break = head.brk;
  assign ev_ascii = head.ascii;

endmodule

// File: tb/tb_kbd_event_decoder.sv
// Directed bench for kbd_event_decoder: prefix decoding, shift/ASCII,
// repeat suppression, FIFO overflow and reset behaviour.
module tb_kbd_event_decoder;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       ev_valid;
  logic       ev_ready = 1'b0;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic [7:0] ev_ascii;
  logic [7:0] press_count;
  logic       shift;
  logic       overflow;
  logic       clr_ovf = 1'b0;
  logic [1:0] dbg_state;

  int checks = 0;
  int failures = 0;

  kbd_event_decoder #(.DEPTH(8), .CNT_W(8)) dut (
    .clk(clk), .clrn(clrn), .in_data(in_data), .in_valid(in_valid),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
    .ev_ext(ev_ext), .ev_break(ev_break), .ev_ascii(ev_ascii),
    .press_count(press_count), .shift(shift), .overflow(overflow),
    .clr_ovf(clr_ovf), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic do_reset();
    clrn = 1'b0; in_valid = 1'b0; ev_ready = 1'b0; clr_ovf = 1'b0;
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
  endtask

  // Drivers: inputs change on the falling edge, outputs are sampled there too
  task automatic send_byte(input logic [7:0] b);
    in_data = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pop_head(output logic [7:0] code, output logic ext, output logic brk,
                          output logic [7:0] ascii, output bit ok);
    ok = 1'b0; code = '0; ext = 1'b0; brk = 1'b0; ascii = '0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (ev_valid) begin
        code = ev_code; ext = ev_ext; brk = ev_break; ascii = ev_ascii; ok = 1'b1;
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (ev_valid !== 1'b0 || ev_code !== 8'h00 || ev_ascii !== 8'h00 || ev_ext !== 1'b0 ||
        ev_break !== 1'b0 || press_count !== 8'd0 || shift !== 1'b0 || overflow !== 1'b0 ||
        dbg_state !== 2'd0) begin
      $display("FAIL reset: valid=%b code=%h ascii=%h ext=%b brk=%b cnt=%0d shift=%b ovf=%b st=%0d, expected all zero",
               ev_valid, ev_code, ev_ascii, ev_ext, ev_break, press_count, shift, overflow, dbg_state);
      failures++;
    end
  endtask

  task automatic test_make_break();
    logic [7:0] c, a; logic e, b; bit ok;
    do_reset();
    send_byte(8'h1C);
    checks++;
    if (ev_valid !== 1'b1) begin
      $display("FAIL latency: ev_valid=%b expected 1 one cycle after byte", ev_valid); failures++;
    end
    send_byte(8'hF0); send_byte(8'h1C);
    pop_head(c, e, b, a, ok);
    checks++;
    if (!ok || c !== 8'h1C || e !== 1'b0 || b !== 1'b0 || a !== 8'h61) begin
      $display("FAIL make_1c: ok=%b code=%h ext=%b brk=%b ascii=%h expected 1c/0/0/61", ok, c, e, b, a);
      failures++;
    end
    pop_head(c, e, b, a, ok);
    checks++;
    if (!ok || c !== 8'h1C || e !== 1'b0 || b !== 1'b1 || a !== 8'h61) begin
      $display("FAIL break_1c: ok=%b code=%h ext=%b brk=%b ascii=%h expected 1c/0/1/61", ok, c, e, b, a);
      failures++;
    end
    checks++;
    if (press_count !== 8'd1 || ev_valid !== 1'b0) begin
      $display("FAIL count_mb: count=%0d valid=%b expected 1/0", press_count, ev_valid); failures++;
    end
  endtask

  task automatic test_shift_repeat();
    logic [7:0] c, a; logic e, b; bit ok;
    logic [7:0] exp_c [4];
    logic       exp_b [4];
    logic [7:0] exp_a [4];
    exp_c = '{8'h12, 8'h1C, 8'h1C, 8'h12};
    exp_b = '{1'b0, 1'b0, 1'b1, 1'b1};
    exp_a = '{8'h00, 8'h41, 8'h41, 8'h00};
    do_reset();
    send_byte(8'h12);
    checks++;
    if (shift !== 1'b1) begin
      $display("FAIL shift_set: shift=%b expected 1", shift); failures++;
    end
    send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h12);
    for (int i = 0; i < 4; i++) begin
      pop_head(c, e, b, a, ok);
      checks++;
      if (!ok || c !== exp_c[i] || e !== 1'b0 || b !== exp_b[i] || a !== exp_a[i]) begin
        $display("FAIL shift_ev%0d: ok=%b code=%h brk=%b ascii=%h expected %h/%b/%h",
                 i, ok, c, b, a, exp_c[i], exp_b[i], exp_a[i]);
        failures++;
      end
    end
    checks++;
    if (ev_valid !== 1'b0 || press_count !== 8'd2 || shift !== 1'b0) begin
      $display("FAIL shift_end: valid=%b count=%0d shift=%b expected 0/2/0", ev_valid, press_count, shift);
      failures++;
    end
  endtask

  task automatic test_extended();
    logic [7:0] c, a; logic e, b; bit ok;
    do_reset();
    send_byte(8'hE0);
    checks++;
    if (dbg_state !== 2'd1) begin
      $display("FAIL state_ext: state=%0d expected 1", dbg_state); failures++;
    end
    send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    send_byte(8'hF0); send_byte(8'hE0); send_byte(8'h1C);
    pop_head(c, e, b, a, ok);
    checks++;
    if (!ok || c !== 8'h75 || e !== 1'b1 || b !== 1'b0 || a !== 8'h00) begin
      $display("FAIL ext_make: ok=%b code=%h ext=%b brk=%b ascii=%h expected 75/1/0/00", ok, c, e, b, a);
      failures++;
    end
    pop_head(c, e, b, a, ok);
    checks++;
    if (!ok || c !== 8'h75 || e !== 1'b1 || b !== 1'b1 || a !== 8'h00) begin
      $display("FAIL ext_break: ok=%b code=%h ext=%b brk=%b ascii=%h expected 75/1/1/00", ok, c, e, b, a);
      failures++;
    end
    pop_head(c, e, b, a, ok);
    checks++;
    if (!ok || c !== 8'h1C || e !== 1'b0 || b !== 1'b0 || a !== 8'h61) begin
      $display("FAIL f0e0_discard: ok=%b code=%h ext=%b brk=%b ascii=%h expected 1c/0/0/61", ok, c, e, b, a);
      failures++;
    end
    checks++;
    if (press_count !== 8'd2) begin
      $display("FAIL ext_count: count=%0d expected 2", press_count); failures++;
    end
  endtask

  task automatic test_overflow();
    logic [7:0] c, a; logic e, b; bit ok;
    logic [7:0] codes [10];
    codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};
    do_reset();
    for (int i = 0; i < 9; i++) send_byte(codes[i]);
    checks++;
    if (overflow !== 1'b1 || press_count !== 8'd9) begin
      $display("FAIL ovf_set: ovf=%b count=%0d expected 1/9", overflow, press_count); failures++;
    end
    clr_ovf = 1'b1;
    send_byte(codes[9]);
    clr_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b1) begin
      $display("FAIL ovf_clr_vs_drop: ovf=%b expected 1", overflow); failures++;
    end
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      $display("FAIL ovf_clear: ovf=%b expected 0", overflow); failures++;
    end
    for (int i = 0; i < 8; i++) begin
      pop_head(c, e, b, a, ok);
      checks++;
      if (!ok || c !== codes[i] || b !== 1'b0 || a !== (8'h31 + 8'(i))) begin
        $display("FAIL ovf_pop%0d: ok=%b code=%h brk=%b ascii=%h expected %h/0/%h",
                 i, ok, c, b, a, codes[i], 8'h31 + 8'(i));
        failures++;
      end
    end
    checks++;
    if (ev_valid !== 1'b0) begin
      $display("FAIL ovf_empty: valid=%b expected 0", ev_valid); failures++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] c, a; logic e, b; bit ok;
    logic [7:0] fill [9];
    fill = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
    do_reset();
    for (int i = 0; i < 8; i++) send_byte(fill[i]);
    in_data = fill[8]; in_valid = 1'b1; ev_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; ev_ready = 1'b0;
    checks++;
    if (overflow !== 1'b0 || ev_valid !== 1'b1) begin
      $display("FAIL full_push_pop: ovf=%b valid=%b expected 0/1", overflow, ev_valid); failures++;
    end
    for (int i = 1; i < 9; i++) begin
      pop_head(c, e, b, a, ok);
      checks++;
      if (!ok || c !== fill[i] || b !== 1'b0) begin
        $display("FAIL b2b_pop%0d: ok=%b code=%h brk=%b expected %h/0", i, ok, c, b, fill[i]);
        failures++;
      end
    end
    checks++;
    if (ev_valid !== 1'b0) begin
      $display("FAIL b2b_empty: valid=%b expected 0", ev_valid); failures++;
    end
  endtask

  task automatic test_reset_mid_prefix();
    logic [7:0] c, a; logic e, b; bit ok;
    do_reset();
    send_byte(8'hE0);
    clrn = 1'b0;
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    checks++;
    if (dbg_state !== 2'd0 || ev_valid !== 1'b0) begin
      $display("FAIL mid_reset_state: state=%0d valid=%b expected 0/0", dbg_state, ev_valid); failures++;
    end
    send_byte(8'h16);
    pop_head(c, e, b, a, ok);
    checks++;
    if (!ok || c !== 8'h16 || e !== 1'b0 || b !== 1'b0 || a !== 8'h31) begin
      $display("FAIL mid_reset_make: ok=%b code=%h ext=%b brk=%b ascii=%h expected 16/0/0/31", ok, c, e, b, a);
      failures++;
    end
  endtask

  task automatic test_saturate();
    do_reset();
    ev_ready = 1'b1;
    for (int i = 0; i < 255; i++) send_byte((i % 2 == 0) ? 8'h1C : 8'h32);
    checks++;
    if (press_count !== 8'hFF) begin
      $display("FAIL sat_reach: count=%0d expected 255", press_count); failures++;
    end
    send_byte(8'h1C);
    ev_ready = 1'b0;
    checks++;
    if (press_count !== 8'hFF || overflow !== 1'b0) begin
      $display("FAIL sat_hold: count=%0d ovf=%b expected 255/0", press_count, overflow); failures++;
    end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_shift_repeat();
    test_extended();
    test_overflow();
    test_back_to_back();
    test_reset_mid_prefix();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
